jtcop_dtack: RTL and testbench

JTCOP_DTACK -- requirements
Module: jtcop_dtack

---
 rtl/jtcop_dtack.sv | 130 +++++++++++++
 tb/tb_jtcop_dtack.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_dtack.sv
// 68000 DTACK generator with fractional CPU clock enables. Ticks swallowed
// while the CPU waits on SDRAM are owed and repaid once the access ends.
module jtcop_dtack #(
  parameter int NUM = 5,
  parameter int DEN = 12,
  parameter int W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic ASn,
  input  logic bus_cs,
  input  logic bus_ok,
  output logic DTACKn,
  output logic cpu_cen,
  output logic cpu_cenb
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   acc_sum;
  logic         nat_tick;
  logic         as_l_q;
  logic         as_fall;
  logic [1:0]   ok_cnt_q, ok_cnt_d;
  logic [3:0]   owed_q, owed_d;
  logic         phase_q, phase_d;
  logic         dtackn_q, dtackn_d;
  logic         cen_q, cenb_q;
  logic         cen_d, cenb_d;
  logic         emit;
  logic         in_wait;

  assign acc_sum  = {1'b0, acc_q} + (W+1)'(NUM);
  assign nat_tick = (acc_sum >= (W+1)'(DEN));
  assign acc_d    = nat_tick ? W'(acc_sum - (W+1)'(DEN)) : acc_sum[W-1:0];
  assign as_fall  = !ASn && as_l_q;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ok_cnt_d = ok_cnt_q;
    dtackn_d = dtackn_q;
    case (state_q)
      IDLE: begin
        dtackn_d = 1'b1;
        if (as_fall) begin
          state_d  = bus_cs ? WAIT : ACK;
          ok_cnt_d = 2'd0;
        end
      end
      WAIT: begin
        if (ASn) begin
          state_d  = IDLE;
          dtackn_d = 1'b1;
        end else if (bus_ok) begin
          ok_cnt_d = ok_cnt_q + 2'd1;
          if (ok_cnt_d == 2'd2) begin
            state_d  = ACK;
            dtackn_d = 1'b0;
          end
        end else begin
          ok_cnt_d = 2'd0;
        end
      end
      ACK: begin
        dtackn_d = ASn;
        if (ASn) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        dtackn_d = 1'b1;
      end
    endcase
  end

  // Suppression looks at the next state so a tick on the WAIT entry edge is owed.
  assign in_wait = (state_d == WAIT);

  always_comb begin
    emit   = 1'b0;
    owed_d = owed_q;
    if (in_wait) begin
      if (nat_tick && owed_q != 4'hF) owed_d = owed_q + 4'd1;
    end else if (nat_tick) begin
      emit = 1'b1;
    end else if (owed_q != 4'd0 && !(cen_q || cenb_q)) begin
      emit   = 1'b1;
      owed_d = owed_q - 4'd1;
    end
    cen_d   = emit && !phase_q;
    cenb_d  = emit && phase_q;
    phase_d = emit ? !phase_q : phase_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      as_l_q   <= 1'b1;
      ok_cnt_q <= 2'd0;
      owed_q   <= 4'd0;
      phase_q  <= 1'b0;
      dtackn_q <= 1'b1;
      cen_q    <= 1'b0;
      cenb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      as_l_q   <= ASn;
      ok_cnt_q <= ok_cnt_d;
      owed_q   <= owed_d;
      phase_q  <= phase_d;
      dtackn_q <= dtackn_d;
      cen_q    <= cen_d;
      cenb_q   <= cenb_d;
    end
  end

  assign DTACKn   = dtackn_q;
  assign cpu_cen  = cen_q;
  assign cpu_cenb = cenb_q;

endmodule

// File: tb/tb_jtcop_dtack.sv
// Bench for jtcop_dtack: directed scenarios plus random bus traffic, all
// compared cycle by cycle against a behavioural model of the block.
module tb_jtcop_dtack;
  localparam int NUM = 5;
  localparam int DEN = 12;

  logic clk = 1'b0;
  logic rst, ASn, bus_cs, bus_ok;
  logic DTACKn, cpu_cen, cpu_cenb;

  always #5 clk = ~clk;

  jtcop_dtack dut (
    .clk      (clk),
    .rst      (rst),
    .ASn      (ASn),
    .bus_cs   (bus_cs),
    .bus_ok   (bus_ok),
    .DTACKn   (DTACKn),
    .cpu_cen  (cpu_cen),
    .cpu_cenb (cpu_cenb)
  );

  int errors = 0;
  int checks = 0;

  typedef enum {M_IDLE, M_WAIT, M_ACK} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_n = 0, m_ok = 0, m_owed = 0;
  bit    m_as_prev = 1'b1, m_phase = 1'b0;
  bit    m_dtackn = 1'b1, m_cen = 1'b0, m_cenb = 1'b0;

  int emit_cnt = 0, nat_cnt = 0, cen_cnt = 0, cenb_cnt = 0;
  bit last_nat = 1'b0, dut_tick = 1'b0, prev_dut_tick = 1'b0;

  // Natural ticks come from the closed form floor(n*NUM/DEN), n = edges since reset.
  task automatic step();
    bit    fall, nat, emit, was_tick;
    mode_t nmode;
    if (rst) begin
      m_n = 0; m_mode = M_IDLE; m_ok = 0; m_as_prev = 1'b1; m_owed = 0;
      m_phase = 1'b0; m_dtackn = 1'b1; m_cen = 1'b0; m_cenb = 1'b0;
      nat = 1'b0;
    end else begin
      fall = !ASn && m_as_prev;
      m_n++;
      nat = ((m_n * NUM) / DEN) != (((m_n - 1) * NUM) / DEN);
      nmode = m_mode;
      case (m_mode)
        M_IDLE: if (fall) begin nmode = bus_cs ? M_WAIT : M_ACK; m_ok = 0; end
        M_WAIT: begin
          if (ASn) nmode = M_IDLE;
          else if (bus_ok) begin m_ok++; if (m_ok == 2) nmode = M_ACK; end
          else m_ok = 0;
        end
        M_ACK: if (ASn) nmode = M_IDLE;
        default: nmode = M_IDLE;
      endcase
      m_dtackn = !(nmode == M_ACK && m_mode != M_IDLE);
      was_tick = m_cen | m_cenb;
      emit = 1'b0;
      if (nmode == M_WAIT) begin
        if (nat) m_owed = (m_owed < 15) ? m_owed + 1 : 15;
      end else if (nat) emit = 1'b1;
      else if (m_owed > 0 && !was_tick) begin emit = 1'b1; m_owed--; end
      m_cen  = emit && !m_phase;
      m_cenb = emit && m_phase;
      if (emit) m_phase = !m_phase;
      m_as_prev = ASn;
      m_mode = nmode;
    end
    last_nat = nat;
    if (nat) nat_cnt++;
    @(posedge clk);
    @(negedge clk);
    prev_dut_tick = dut_tick;
    dut_tick = cpu_cen | cpu_cenb;
    if (dut_tick) emit_cnt++;
    if (cpu_cen) cen_cnt++;
    if (cpu_cenb) cenb_cnt++;
  endtask

  task automatic clear_counts();
    emit_cnt = 0; nat_cnt = 0; cen_cnt = 0; cenb_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ASn = 1'b1; bus_cs = 1'b0; bus_ok = 1'b0;
    repeat (3) step();
    checks++;
    if ({DTACKn, cpu_cen, cpu_cenb} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: got dtackn/cen/cenb=%b expected 100", {DTACKn, cpu_cen, cpu_cenb});
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    bit exp_b = 1'b0, alt_bad = 1'b0, coinc = 1'b0;
    clear_counts();
    for (int i = 0; i < 240; i++) begin
      step();
      checks++;
      if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
        errors++;
        $display("FAIL free_run[%0d]: got %b expected %b", i, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
      end
      if (cpu_cen && cpu_cenb) coinc = 1'b1;
      if (cpu_cen || cpu_cenb) begin
        if (cpu_cenb !== exp_b) alt_bad = 1'b1;
        exp_b = !exp_b;
      end
    end
    checks++;
    if (emit_cnt != 100) begin errors++; $display("FAIL free_run_ticks: got %0d expected 100", emit_cnt); end
    checks++;
    if (cen_cnt != 50) begin errors++; $display("FAIL free_run_cen: got %0d expected 50", cen_cnt); end
    checks++;
    if (cenb_cnt != 50) begin errors++; $display("FAIL free_run_cenb: got %0d expected 50", cenb_cnt); end
    checks++;
    if (alt_bad) begin errors++; $display("FAIL free_run_alternate: got out-of-order tick expected strict alternation"); end
    checks++;
    if (coinc) begin errors++; $display("FAIL free_run_coincident: got cen&cenb together expected never"); end
  endtask

  task automatic test_no_wait();
    int hold = $urandom_range(1, 5);
    bus_cs = 1'b0; ASn = 1'b0;
    step();
    checks++;
    if (DTACKn !== 1'b1) begin errors++; $display("FAIL nowait_first_clk: got DTACKn=%b expected 1", DTACKn); end
    step();
    checks++;
    if (DTACKn !== 1'b0) begin errors++; $display("FAIL nowait_second_clk: got DTACKn=%b expected 0", DTACKn); end
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
        errors++;
        $display("FAIL nowait_hold[%0d]: got %b expected %b", i, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
      end
    end
    ASn = 1'b1;
    step();
    checks++;
    if (DTACKn !== 1'b1) begin errors++; $display("FAIL nowait_release: got DTACKn=%b expected 1", DTACKn); end
  endtask

  task automatic test_wait_ack();
    bit quiet = 1'b1, dt_bad = 1'b0, adj_bad = 1'b0;
    int ack_hold = $urandom_range(1, 4);
    rst = 1'b1; step(); rst = 1'b0;
    ASn = 1'b0; bus_cs = 1'b1; bus_ok = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 30) bus_ok = 1'b1;
      step();
      checks++;
      if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
        errors++;
        $display("FAIL wait_cycle[%0d]: got %b expected %b", i, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
      end
      if (cpu_cen || cpu_cenb) quiet = 1'b0;
      if (DTACKn !== 1'b1) dt_bad = 1'b1;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL wait_no_cen: got cen pulse expected none during WAIT"); end
    checks++;
    if (dt_bad) begin errors++; $display("FAIL wait_dtack_high: got DTACKn=0 expected 1 during WAIT"); end
    clear_counts();
    step();
    checks++;
    if (DTACKn !== 1'b0) begin errors++; $display("FAIL wait_ack_latency: got DTACKn=%b expected 0", DTACKn); end
    for (int i = 0; i < 150; i++) begin
      if (i == ack_hold) begin ASn = 1'b1; bus_ok = 1'b0; bus_cs = 1'b0; end
      step();
      checks++;
      if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
        errors++;
        $display("FAIL wait_recover[%0d]: got %b expected %b", i, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
      end
      if (dut_tick && !last_nat && prev_dut_tick) adj_bad = 1'b1;
    end
    checks++;
    if (emit_cnt - nat_cnt != 12) begin
      errors++;
      $display("FAIL wait_owed_repaid: got %0d extra ticks expected 12", emit_cnt - nat_cnt);
    end
    checks++;
    if (adj_bad) begin errors++; $display("FAIL wait_recovery_spacing: got extra tick after a tick expected gap"); end
  endtask

  task automatic test_glitch();
    bit dt_bad = 1'b0;
    int pre = $urandom_range(1, 4);
    ASn = 1'b0; bus_cs = 1'b1; bus_ok = 1'b0;
    for (int i = 0; i < pre + 5; i++) begin
      bus_ok = (i == pre);
      step();
      if (DTACKn !== 1'b1) dt_bad = 1'b1;
    end
    checks++;
    if (dt_bad) begin errors++; $display("FAIL glitch_ignored: got DTACKn=0 expected 1 after one-clk bus_ok"); end
    bus_ok = 1'b1;
    step();
    checks++;
    if (DTACKn !== 1'b1) begin errors++; $display("FAIL glitch_first_ok: got DTACKn=%b expected 1", DTACKn); end
    step();
    checks++;
    if (DTACKn !== 1'b0) begin errors++; $display("FAIL glitch_steady_pair: got DTACKn=%b expected 0", DTACKn); end
    ASn = 1'b1; bus_ok = 1'b0; bus_cs = 1'b0;
    step();
    checks++;
    if (DTACKn !== 1'b1) begin errors++; $display("FAIL glitch_release: got DTACKn=%b expected 1", DTACKn); end
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
        errors++;
        $display("FAIL glitch_drain[%0d]: got %b expected %b", i, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
      end
    end
  endtask

  task automatic test_saturate();
    bit quiet = 1'b1, dt_bad = 1'b0;
    ASn = 1'b0; bus_cs = 1'b1; bus_ok = 1'b0;
    repeat (200) begin
      step();
      if (cpu_cen || cpu_cenb) quiet = 1'b0;
      if (DTACKn !== 1'b1) dt_bad = 1'b1;
    end
    checks++;
    if (!quiet || dt_bad) begin
      errors++;
      $display("FAIL sat_wait: got quiet=%0d dtack_high=%0d expected 1 1", quiet, !dt_bad);
    end
    ASn = 1'b1; bus_cs = 1'b0;
    clear_counts();
    step();
    checks++;
    if (DTACKn !== 1'b1) begin errors++; $display("FAIL sat_abort: got DTACKn=%b expected 1", DTACKn); end
    for (int i = 0; i < 149; i++) begin
      step();
      checks++;
      if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
        errors++;
        $display("FAIL sat_recover[%0d]: got %b expected %b", i, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
      end
    end
    checks++;
    if (emit_cnt - nat_cnt != 15) begin
      errors++;
      $display("FAIL sat_owed: got %0d extra ticks expected 15", emit_cnt - nat_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    rst = 1'b1; step(); rst = 1'b0;
    ASn = 1'b0; bus_cs = 1'b1; bus_ok = 1'b0;
    repeat (18) step();
    rst = 1'b1; ASn = 1'b1; bus_cs = 1'b0;
    step();
    checks++;
    if ({DTACKn, cpu_cen, cpu_cenb} !== 3'b100) begin
      errors++;
      $display("FAIL rst_in_wait: got %b expected 100", {DTACKn, cpu_cen, cpu_cenb});
    end
    rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 80; i++) begin
      step();
      checks++;
      if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
        errors++;
        $display("FAIL rst_after[%0d]: got %b expected %b", i, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
      end
    end
    checks++;
    if (emit_cnt != nat_cnt) begin
      errors++;
      $display("FAIL rst_no_recovery: got %0d ticks expected %0d", emit_cnt, nat_cnt);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    while (cyc < 1500) begin
      int gap  = $urandom_range(1, 6);
      int hold = $urandom_range(1, 40);
      ASn = 1'b1;
      rst = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < gap + hold; i++) begin
        if (i == 1) rst = 1'b0;
        if (i == gap) begin ASn = 1'b0; bus_cs = $urandom_range(0, 1); end
        bus_ok = ($urandom_range(0, 3) != 0);
        step();
        cyc++;
        checks++;
        if ({DTACKn, cpu_cen, cpu_cenb} !== {m_dtackn, m_cen, m_cenb}) begin
          errors++;
          $display("FAIL random[%0d]: got %b expected %b", cyc, {DTACKn, cpu_cen, cpu_cenb}, {m_dtackn, m_cen, m_cenb});
        end
      end
      rst = 1'b0;
    end
    ASn = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ASn = 1'b1; bus_cs = 1'b0; bus_ok = 1'b0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_no_wait();
    test_wait_ack();
    test_glitch();
    test_saturate();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
